// File: rtl/nabp_line_buffer_controller_pkg.sv
// Shared types and defaults for the NABP line buffer controller.
// Optional statistics build: NABP_LINE_BUF_STATS_EN.
package nabp_line_buffer_controller_pkg;

    localparam int kFilteredDataLength = 16;
    localparam int kProjectionLineSize = 16;
    localparam int kSLength            = 4;
    localparam int kLineBufNumReaders  = 4;
    localparam int kLineBufIdLength    = 2;

    typedef enum logic {
        kLineBufStateFill  = 1'b0,
        kLineBufStateServe = 1'b1
    } line_buf_state_e;

    localparam logic [31:0] kStatMax = '1;

endpackage

// File: rtl/nabp_line_buffer_controller_if.sv
// Filter-stream and reader handshake bundle of the line buffer controller.
// Optional statistics build: NABP_LINE_BUF_STATS_EN (adds no signals here).
interface nabp_line_buffer_controller_if #(
    parameter int pDataLength = 16,
    parameter int pAddrLength = 4,
    parameter int pNumReaders = 4,
    parameter int pIdLength   = 2
);
    logic                               fill_valid;
    logic [pDataLength-1:0]             fill_data;
    logic                               fill_ready;
    logic                               line_valid;
    logic [pNumReaders-1:0]             rd_req;
    logic [pNumReaders*pAddrLength-1:0] rd_addr;
    logic [pNumReaders-1:0]             rd_done;
    logic [pNumReaders-1:0]             rd_gnt;
    logic                               rd_valid_0;
    logic                               rd_valid_1;
    logic [pIdLength-1:0]               rd_id_0;
    logic [pIdLength-1:0]               rd_id_1;
    logic [pDataLength-1:0]             rd_data_0;
    logic [pDataLength-1:0]             rd_data_1;

    modport master (
        output fill_valid, fill_data, rd_req, rd_addr, rd_done,
        input  fill_ready, line_valid, rd_gnt,
        input  rd_valid_0, rd_valid_1, rd_id_0, rd_id_1,
        input  rd_data_0, rd_data_1
    );

    modport slave (
        input  fill_valid, fill_data, rd_req, rd_addr, rd_done,
        output fill_ready, line_valid, rd_gnt,
        output rd_valid_0, rd_valid_1, rd_id_0, rd_id_1,
        output rd_data_0, rd_data_1
    );
endinterface

// File: rtl/nabp_line_buffer_controller_arbiter.sv
// Combinational pick-two round-robin arbiter for the two RAM ports.
// Optional statistics build: NABP_LINE_BUF_STATS_EN (not used here).
module nabp_rr_pick2_arbiter #(
    parameter int pNumReaders = 4,
    parameter int pIdLength   = 2
) (
    input  logic [pNumReaders-1:0] elig,
    input  logic [pIdLength-1:0]   rr_ptr,
    output logic [pNumReaders-1:0] gnt_0,
    output logic [pNumReaders-1:0] gnt_1,
    output logic                   vld_0,
    output logic                   vld_1,
    output logic [pIdLength-1:0]   rr_next
);
    int                 s;
    logic [pIdLength-1:0] idx;
    logic [pIdLength-1:0] after;

    always_comb begin
        gnt_0   = '0;
        gnt_1   = '0;
        vld_0   = 1'b0;
        vld_1   = 1'b0;
        rr_next = rr_ptr;
        s       = 0;
        idx     = '0;
        after   = '0;
        for (int k = 0; k < pNumReaders; k++) begin
            s = int'(rr_ptr) + k;
            if (s >= pNumReaders) s = s - pNumReaders;
            idx   = pIdLength'(s);
            after = (s == pNumReaders - 1) ? '0 : pIdLength'(s + 1);
            if (elig[idx]) begin
                if (!vld_0) begin
                    vld_0      = 1'b1;
                    gnt_0[idx] = 1'b1;
                    rr_next    = after;
                end else if (!vld_1) begin
                    vld_1      = 1'b1;
                    gnt_1[idx] = 1'b1;
                    rr_next    = after;
                end
            end
        end
    end
endmodule

// File: rtl/nabp_line_buffer_controller.sv
// Line buffer controller: fills one projection line, then serves two reads/cycle.
// Define NABP_LINE_BUF_STATS_EN to add grant/stall statistics outputs.
module nabp_line_buffer_controller
    import nabp_line_buffer_controller_pkg::*;
#(
    parameter int pDataLength = kFilteredDataLength,
    parameter int pRAMSize    = kProjectionLineSize,
    parameter int pAddrLength = kSLength,
    parameter int pNumReaders = kLineBufNumReaders,
    parameter int pIdLength   = kLineBufIdLength
) (
    input  logic                   clk,
    input  logic                   reset,
    nabp_line_buffer_controller_if.slave bus,
    output logic                   ram_we_0,
    output logic [pAddrLength-1:0] ram_addr_0,
    output logic [pDataLength-1:0] ram_data_in_0,
    input  logic [pDataLength-1:0] ram_data_out_0,
    output logic                   ram_we_1,
    output logic [pAddrLength-1:0] ram_addr_1,
    output logic [pDataLength-1:0] ram_data_in_1,
    input  logic [pDataLength-1:0] ram_data_out_1
`ifdef NABP_LINE_BUF_STATS_EN
    ,
    output logic [31:0]            stat_grant_count,
    output logic [31:0]            stat_stall_count
`endif
);
    line_buf_state_e state, state_next;

    logic [pAddrLength-1:0] wr_ptr;
    logic [pNumReaders-1:0] done_mask, done_next, elig;
    logic [pNumReaders-1:0] gnt_0, gnt_1;
    logic [pIdLength-1:0]   rr_ptr, rr_next, id_0, id_1;
    logic [pIdLength-1:0]   id_q_0, id_q_1;
    logic [pAddrLength-1:0] addr_0, addr_1;
    logic vld_0, vld_1, vld_q_0, vld_q_1;
    logic serve, accept, last_fill, exit_serve;

    assign serve      = state == kLineBufStateServe;
    assign accept     = bus.fill_valid && bus.fill_ready;
    assign last_fill  = wr_ptr == pAddrLength'(pRAMSize - 1);
    assign elig       = serve ? (bus.rd_req & ~done_mask) : '0;
    assign done_next  = done_mask | (serve ? bus.rd_done : '0);
    // Returns already on the lanes must drain before the line is released.
    assign exit_serve = serve && (&done_next) && !(vld_q_0 || vld_q_1);

    nabp_rr_pick2_arbiter #(
        .pNumReaders(pNumReaders),
        .pIdLength  (pIdLength)
    ) u_arb (
        .elig   (elig),
        .rr_ptr (rr_ptr),
        .gnt_0  (gnt_0),
        .gnt_1  (gnt_1),
        .vld_0  (vld_0),
        .vld_1  (vld_1),
        .rr_next(rr_next)
    );

    always_comb begin
        id_0   = '0;
        id_1   = '0;
        addr_0 = '0;
        addr_1 = '0;
        for (int i = 0; i < pNumReaders; i++) begin
            if (gnt_0[i]) begin
                id_0   = pIdLength'(i);
                addr_0 = bus.rd_addr[i*pAddrLength +: pAddrLength];
            end
            if (gnt_1[i]) begin
                id_1   = pIdLength'(i);
                addr_1 = bus.rd_addr[i*pAddrLength +: pAddrLength];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= kLineBufStateFill;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            kLineBufStateFill:
                if (accept && last_fill) state_next = kLineBufStateServe;
            kLineBufStateServe:
                if (exit_serve) state_next = kLineBufStateFill;
        endcase
    end

    always_comb begin
        bus.fill_ready = !serve && !reset;
        bus.line_valid = serve;
        bus.rd_gnt     = gnt_0 | gnt_1;
        ram_we_0       = accept;
        ram_addr_0     = accept ? wr_ptr : addr_0;
        ram_data_in_0  = accept ? bus.fill_data : '0;
        ram_we_1       = 1'b0;
        ram_addr_1     = addr_1;
        ram_data_in_1  = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            done_mask <= '0;
            rr_ptr    <= '0;
            vld_q_0   <= 1'b0;
            vld_q_1   <= 1'b0;
            id_q_0    <= '0;
            id_q_1    <= '0;
        end else begin
            if (accept) wr_ptr <= last_fill ? '0 : wr_ptr + 1'b1;
            if (exit_serve) begin
                wr_ptr    <= '0;
                done_mask <= '0;
            end else begin
                done_mask <= done_next;
            end
            if (vld_0) rr_ptr <= rr_next;
            vld_q_0 <= vld_0;
            vld_q_1 <= vld_1;
            id_q_0  <= id_0;
            id_q_1  <= id_1;
        end
    end

    assign bus.rd_valid_0 = vld_q_0;
    assign bus.rd_valid_1 = vld_q_1;
    assign bus.rd_id_0    = id_q_0;
    assign bus.rd_id_1    = id_q_1;
    assign bus.rd_data_0  = ram_data_out_0;
    assign bus.rd_data_1  = ram_data_out_1;

`ifdef NABP_LINE_BUF_STATS_EN
    logic [31:0] n_gnt;
    logic        stall;

    assign n_gnt = 32'(vld_0) + 32'(vld_1);
    assign stall = (elig & ~(gnt_0 | gnt_1)) != '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grant_count <= '0;
            stat_stall_count <= '0;
        end else begin
            if (stat_grant_count > kStatMax - n_gnt)
                stat_grant_count <= kStatMax;
            else
                stat_grant_count <= stat_grant_count + n_gnt;
            if (stall && stat_stall_count != kStatMax)
                stat_stall_count <= stat_stall_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_nabp_line_buffer_controller.sv
// Bench for nabp_line_buffer_controller: directed stimulus, behavioural model.
// Stats outputs are connected when NABP_LINE_BUF_STATS_EN is defined.
module tb_nabp_line_buffer_controller;
    localparam int N  = 4;
    localparam int S  = 16;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic reset;

    nabp_line_buffer_controller_if #(
        .pDataLength(DW), .pAddrLength(AW),
        .pNumReaders(N), .pIdLength(IW)
    ) bus ();

    logic          ram_we_0, ram_we_1;
    logic [AW-1:0] ram_addr_0, ram_addr_1;
    logic [DW-1:0] ram_data_in_0, ram_data_in_1;
    logic [DW-1:0] ram_data_out_0, ram_data_out_1;
    logic [DW-1:0] ram [S];
`ifdef NABP_LINE_BUF_STATS_EN
    logic [31:0] stat_grant_count, stat_stall_count;
`endif

    nabp_line_buffer_controller #(
        .pDataLength(DW), .pRAMSize(S), .pAddrLength(AW),
        .pNumReaders(N), .pIdLength(IW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .ram_we_0      (ram_we_0),
        .ram_addr_0    (ram_addr_0),
        .ram_data_in_0 (ram_data_in_0),
        .ram_data_out_0(ram_data_out_0),
        .ram_we_1      (ram_we_1),
        .ram_addr_1    (ram_addr_1),
        .ram_data_in_1 (ram_data_in_1),
        .ram_data_out_1(ram_data_out_1)
`ifdef NABP_LINE_BUF_STATS_EN
        ,
        .stat_grant_count(stat_grant_count),
        .stat_stall_count(stat_stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous dual-port RAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_we_0) ram[ram_addr_0] <= ram_data_in_0;
        if (ram_we_1) ram[ram_addr_1] <= ram_data_in_1;
        ram_data_out_0 <= ram[ram_addr_0];
        ram_data_out_1 <= ram[ram_addr_1];
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int raddr(input int r);
        return int'(bus.rd_addr[r*AW +: AW]);
    endfunction

    // Behavioural model of the line and the reader service
    bit            m_known = 0;
    bit            m_serve;
    int            m_wptr, m_rr;
    logic [N-1:0]  m_done;
    logic [DW-1:0] m_mem [S];
    bit            m_pv [2];
    int            m_pid [2];
    int            m_pa [2];
    int            m_gcnt = 0, m_scnt = 0;
    int            q[$];
    int            r, ea0, ea1, last;
    logic [N-1:0]  elig, egnt, dnx;
    bit            acc;

    always @(negedge clk) begin
        if (reset) begin
            chk("fill_ready_rst", bus.fill_ready, 0);
            m_serve = 0; m_wptr = 0; m_rr = 0; m_done = '0;
            m_pv[0] = 0; m_pv[1] = 0;
            m_gcnt = 0; m_scnt = 0;
            m_known = 1;
        end else if (m_known) begin
            q.delete();
            elig = m_serve ? (bus.rd_req & ~m_done) : '0;
            for (int k = 0; k < N; k++) begin
                r = (m_rr + k) % N;
                if (elig[r]) q.push_back(r);
            end
            egnt = '0;
            if (q.size() > 0) egnt[q[0]] = 1'b1;
            if (q.size() > 1) egnt[q[1]] = 1'b1;
            acc = !m_serve && bus.fill_valid;
            ea0 = acc ? m_wptr : (q.size() > 0 ? raddr(q[0]) : 0);
            ea1 = q.size() > 1 ? raddr(q[1]) : 0;
            chk("fill_ready", bus.fill_ready, !m_serve);
            chk("line_valid", bus.line_valid, m_serve);
            chk("rd_gnt", bus.rd_gnt, egnt);
            chk("ram_we_0", ram_we_0, acc);
            chk("ram_addr_0", ram_addr_0, ea0);
            chk("ram_din_0", ram_data_in_0, acc ? bus.fill_data : 0);
            chk("ram_we_1", ram_we_1, 0);
            chk("ram_addr_1", ram_addr_1, ea1);
            chk("ram_din_1", ram_data_in_1, 0);
            chk("rd_valid_0", bus.rd_valid_0, m_pv[0]);
            chk("rd_valid_1", bus.rd_valid_1, m_pv[1]);
            if (m_pv[0]) begin
                chk("rd_id_0", bus.rd_id_0, m_pid[0]);
                chk("rd_data_0", bus.rd_data_0, m_mem[m_pa[0]]);
            end
            if (m_pv[1]) begin
                chk("rd_id_1", bus.rd_id_1, m_pid[1]);
                chk("rd_data_1", bus.rd_data_1, m_mem[m_pa[1]]);
            end
            if (acc) begin
                m_mem[m_wptr] = bus.fill_data;
                m_wptr++;
                if (m_wptr == S) begin
                    m_wptr = 0;
                    m_serve = 1;
                end
            end else if (m_serve) begin
                m_gcnt += (q.size() > 2) ? 2 : q.size();
                if (q.size() > 2) m_scnt++;
                dnx = m_done | bus.rd_done;
                if (&dnx && !m_pv[0] && !m_pv[1]) begin
                    m_serve = 0;
                    m_done = '0;
                end else begin
                    m_done = dnx;
                end
            end
            m_pv[0] = q.size() > 0;
            m_pv[1] = q.size() > 1;
            if (q.size() > 0) begin
                m_pid[0] = q[0]; m_pa[0] = raddr(q[0]);
                last = q[0];
            end
            if (q.size() > 1) begin
                m_pid[1] = q[1]; m_pa[1] = raddr(q[1]);
                last = q[1];
            end
            if (q.size() > 0) m_rr = (last + 1) % N;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_addr(input int rd, input int a);
        bus.rd_addr[rd*AW +: AW] = AW'(a);
    endtask

    initial begin
        reset = 1'b1;
        bus.fill_valid = 1'b0;
        bus.fill_data  = '0;
        bus.rd_req     = '0;
        bus.rd_addr    = '0;
        bus.rd_done    = '0;
        step(); step();
        reset = 1'b0;
        settle();
        chk("lit_rst_ready", bus.fill_ready, 1);
        chk("lit_rst_line", bus.line_valid, 0);
        chk("lit_rst_v0", bus.rd_valid_0, 0);

        // Stream one full line back to back
        for (int k = 0; k < S; k++) begin
            bus.fill_valid = 1'b1;
            bus.fill_data  = DW'(16'hA000 + k);
            step();
        end
        bus.fill_valid = 1'b0;
        settle();
        chk("lit_fill_done_ready", bus.fill_ready, 0);
        chk("lit_fill_done_line", bus.line_valid, 1);
        for (int k = 0; k < S; k++)
            chk("lit_ram_line_a", ram[k], DW'(16'hA000 + k));

        // Two simultaneous readers
        set_addr(0, 5);
        set_addr(2, 9);
        bus.rd_req = 4'b0101;
        settle();
        chk("lit_gnt_02", bus.rd_gnt, 4'b0101);
        step();
        bus.rd_req = '0;
        settle();
        chk("lit_v0", bus.rd_valid_0, 1);
        chk("lit_id0", bus.rd_id_0, 0);
        chk("lit_d0", bus.rd_data_0, 16'hA005);
        chk("lit_v1", bus.rd_valid_1, 1);
        chk("lit_id1", bus.rd_id_1, 2);
        chk("lit_d1", bus.rd_data_1, 16'hA009);

        // Reader 3 alone brings the pointer back to 0
        set_addr(3, 1);
        bus.rd_req = 4'b1000;
        step();
        bus.rd_req = '0;
        step();

        // Four contending readers
        for (int i = 0; i < N; i++) set_addr(i, 2 * i + 2);
        bus.rd_req = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("lit_gnt_rr", bus.rd_gnt, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            step();
        end
        bus.rd_req = '0;
        step();

        // Staggered retirement, reader 3 reads in its done cycle
        bus.rd_done = 4'b0001; step();
        bus.rd_done = 4'b0010; step();
        bus.rd_done = 4'b0100; step();
        bus.rd_done = '0;      step();
        set_addr(3, 7);
        bus.rd_req  = 4'b1000;
        bus.rd_done = 4'b1000;
        settle();
        chk("lit_gnt_3", bus.rd_gnt, 4'b1000);
        chk("lit_ready_exit", bus.fill_ready, 0);
        step();
        bus.rd_req  = '0;
        bus.rd_done = '0;
        settle();
        chk("lit_ready_refill", bus.fill_ready, 1);
        chk("lit_line_refill", bus.line_valid, 0);
        chk("lit_v0_3", bus.rd_valid_0, 1);
        chk("lit_id0_3", bus.rd_id_0, 3);
        chk("lit_d0_3", bus.rd_data_0, 16'hA007);

        // Gappy fill with requests that must be ignored
        for (int k = 0; k < S; k++) begin
            bus.fill_valid = 1'b0;
            bus.rd_req = 4'b1111;
            settle();
            chk("lit_gnt_fill", bus.rd_gnt, 0);
            step();
            bus.rd_req = '0;
            bus.fill_valid = 1'b1;
            bus.fill_data  = DW'(16'hB000 + k);
            step();
        end
        bus.fill_valid = 1'b0;
        settle();
        chk("lit_line_b", bus.line_valid, 1);
        for (int k = 0; k < S; k++)
            chk("lit_ram_line_b", ram[k], DW'(16'hB000 + k));

        bus.rd_done = 4'b1111;
        step();
        bus.rd_done = '0;

        // Reset in the middle of a fill
        for (int k = 0; k < 10; k++) begin
            bus.fill_valid = 1'b1;
            bus.fill_data  = DW'(16'hC000 + k);
            step();
        end
        bus.fill_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        chk("lit_mid_rst_line", bus.line_valid, 0);
        chk("lit_mid_rst_v0", bus.rd_valid_0, 0);
        chk("lit_mid_rst_v1", bus.rd_valid_1, 0);
        for (int k = 0; k < S; k++) begin
            bus.fill_valid = 1'b1;
            bus.fill_data  = DW'(16'hD000 + k);
            step();
        end
        bus.fill_valid = 1'b0;
        set_addr(1, 0);
        bus.rd_req = 4'b0010;
        step();
        bus.rd_req = '0;
        settle();
        chk("lit_d_addr0", bus.rd_data_0, 16'hD000);
        chk("lit_d_id", bus.rd_id_0, 1);
        step(); step();
`ifdef NABP_LINE_BUF_STATS_EN
        chk("stat_grants", stat_grant_count, m_gcnt);
        chk("stat_stalls", stat_stall_count, m_scnt);
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
